// File: rtl/ctr_feistel_decrypt.sv
// CTR-mode stream cipher over a ROUND-round 256-bit balanced Feistel network; keystream XOR ciphertext.
// Latency: valid rises ROUND*F_LAT+1 clocks after tvalid is raised (31 with defaults); fully pipelined.
// Backpressure: none; one block accepted per clock, outputs emitted in order without stalls.
module ctr_feistel_decrypt #(
    parameter int ROUND      = 5,
    parameter int F_LAT      = 6,
    parameter int SBOX_WIDTH = 8,
    parameter int KEY_SIZE   = 128,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sbox_valid,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    input  logic                  key_tvalid,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] ciphertext,
    input  logic [DATA_WIDTH-1:0] iv,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] plaintext
);

    localparam int HALF       = DATA_WIDTH / 2;
    localparam int NBYTE      = HALF / SBOX_WIDTH;
    localparam int SBOX_DEPTH = 1 << SBOX_WIDTH;
    localparam int KPTR_W     = (ROUND > 1) ? $clog2(ROUND) : 1;
    localparam int DEPTH      = ROUND * F_LAT;

    // F is split as: stage 0 key mix, stage 1 byte substitution, stage 2 linear
    // diffusion, remaining stages pure delay. F_LAT therefore has to be >= 3.

    // Lookup tables, loaded serially after reset
    logic [SBOX_WIDTH-1:0] sbox [SBOX_DEPTH];
    logic [SBOX_WIDTH-1:0] sbox_wptr;
    logic [KEY_SIZE-1:0]   rkey [ROUND];
    logic [KPTR_W-1:0]     kptr;

    // Block counter and the counter block fed into round 0
    logic [DATA_WIDTH-1:0] ctr;
    logic [DATA_WIDTH-1:0] ctr_blk;

    // Per-stage pipeline state: F partial result, and the L/R halves of the
    // round input travelling alongside it so the round output can be formed
    // when F completes.
    logic [HALF-1:0]       f_q  [DEPTH];
    logic [HALF-1:0]       l_q  [DEPTH];
    logic [HALF-1:0]       r_q  [DEPTH];
    logic [DATA_WIDTH-1:0] ct_q [DEPTH];
    logic [DEPTH-1:0]      vld_q;

    // Round inputs: round 0 takes the counter block, later rounds take the
    // previous round's output formed from the last stage of that round.
    logic [HALF-1:0]       rin_l [ROUND];
    logic [HALF-1:0]       rin_r [ROUND];
    logic [DATA_WIDTH-1:0] keystream;

    // F's diffusion layer: s ^ rotl(s,8) ^ rotl(s,32) over the half width
    function automatic logic [HALF-1:0] mix(input logic [HALF-1:0] s);
        return s
             ^ {s[HALF-9:0],  s[HALF-1:HALF-8]}
             ^ {s[HALF-33:0], s[HALF-1:HALF-32]};
    endfunction

    assign ctr_blk = iv + ctr;

    // S-box serial load with a wrapping write pointer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sbox_wptr <= '0;
            for (int i = 0; i < SBOX_DEPTH; i++) begin
                sbox[i] <= '0;
            end
        end else if (sbox_valid) begin
            sbox[sbox_wptr] <= sbox_out;
            sbox_wptr       <= sbox_wptr + SBOX_WIDTH'(1);
        end
    end

    // Round-key serial load; pointer cycles through the ROUND slots
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kptr <= '0;
            for (int i = 0; i < ROUND; i++) begin
                rkey[i] <= '0;
            end
        end else if (key_tvalid) begin
            rkey[kptr] <= key;
            kptr       <= (kptr == KPTR_W'(ROUND - 1)) ? '0 : kptr + KPTR_W'(1);
        end
    end

    // Block counter advances once per accepted block and wraps naturally
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctr <= '0;
        end else if (tvalid) begin
            ctr <= ctr + DATA_WIDTH'(1);
        end
    end

    // Select each round's (L, R) input from the counter block or the prior round
    always_comb begin
        rin_l[0] = ctr_blk[DATA_WIDTH-1:HALF];
        rin_r[0] = ctr_blk[HALF-1:0];
        for (int i = 1; i < ROUND; i++) begin
            rin_l[i] = r_q[i*F_LAT-1];
            rin_r[i] = l_q[i*F_LAT-1] ^ f_q[i*F_LAT-1];
        end
    end

    // No final swap: keystream is {L(ROUND), R(ROUND)}
    assign keystream = {r_q[DEPTH-1], l_q[DEPTH-1] ^ f_q[DEPTH-1]};

    // Feistel datapath: F pipeline per round with L/R riding alongside
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROUND; i++) begin
            for (int j = 0; j < F_LAT; j++) begin
                if (j == 0) begin
                    f_q[i*F_LAT] <= rin_r[i] ^ rkey[i];
                    l_q[i*F_LAT] <= rin_l[i];
                    r_q[i*F_LAT] <= rin_r[i];
                end else begin
                    if (j == 1) begin
                        for (int b = 0; b < NBYTE; b++) begin
                            f_q[i*F_LAT+j][b*SBOX_WIDTH +: SBOX_WIDTH]
                                <= sbox[f_q[i*F_LAT+j-1][b*SBOX_WIDTH +: SBOX_WIDTH]];
                        end
                    end else if (j == 2) begin
                        f_q[i*F_LAT+j] <= mix(f_q[i*F_LAT+j-1]);
                    end else begin
                        f_q[i*F_LAT+j] <= f_q[i*F_LAT+j-1];
                    end
                    l_q[i*F_LAT+j] <= l_q[i*F_LAT+j-1];
                    r_q[i*F_LAT+j] <= r_q[i*F_LAT+j-1];
                end
            end
        end
    end

    // Ciphertext delay line matching the keystream pipeline depth
    always_ff @(posedge clk) begin
        ct_q[0] <= ciphertext;
        for (int n = 1; n < DEPTH; n++) begin
            ct_q[n] <= ct_q[n-1];
        end
    end

    // Valid shift register; cleared on reset so in-flight blocks are dropped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], tvalid};
        end
    end

    // Output register: plaintext only updates with a valid block, otherwise holds
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid     <= 1'b0;
            plaintext <= '0;
        end else begin
            valid <= vld_q[DEPTH-1];
            if (vld_q[DEPTH-1]) begin
                plaintext <= keystream ^ ct_q[DEPTH-1];
            end
        end
    end

endmodule

// File: tb/tb_ctr_feistel_decrypt.sv
// Bench: an encrypt instance chained into a decrypt instance, plus a direct decrypt path.
// Expected keystreams come from a behavioural Feistel model with sbox[i] = 255-i.
// Checks reset state, latency, round trip, back-to-back, linearity, counter wrap and flush.
module tb_ctr_feistel_decrypt;

    localparam logic [255:0] IV  = 256'hAABBCCDDEEFF00112233445566778899_0123456789ABCDEF0011223344556677;
    localparam logic [255:0] PT1 = 256'h11223344556677889900AABBCCDDEEFF_00112233445566778899AABBCCDDEEFF;
    localparam logic [255:0] PT2 = 256'hFFEEDDCCBBAA99887766554433221100_0123456789ABCDEF0011223344556677;

    logic         clk;
    logic         reset_n;
    logic         sbox_valid;
    logic [7:0]   sbox_out;
    logic         key_tvalid;
    logic [127:0] key;
    logic         tb_tvalid;
    logic [255:0] tb_data;
    logic [255:0] iv;
    logic         chain;
    logic         e_valid, d_valid, d_tvalid;
    logic [255:0] e_pt, d_pt, d_ct;

    logic [127:0] key_tab [5];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] iv;
        logic [255:0] ct;
        logic [255:0] exp;
    } vec_t;
    vec_t vecs [5];

    assign d_tvalid = chain ? e_valid : tb_tvalid;
    assign d_ct     = chain ? e_pt    : tb_data;

    ctr_feistel_decrypt u_enc (
        .clk(clk), .reset_n(reset_n),
        .sbox_valid(sbox_valid), .sbox_out(sbox_out),
        .key_tvalid(key_tvalid), .key(key),
        .tvalid(tb_tvalid), .ciphertext(tb_data), .iv(iv),
        .valid(e_valid), .plaintext(e_pt)
    );

    ctr_feistel_decrypt u_dec (
        .clk(clk), .reset_n(reset_n),
        .sbox_valid(sbox_valid), .sbox_out(sbox_out),
        .key_tvalid(key_tvalid), .key(key),
        .tvalid(d_tvalid), .ciphertext(d_ct), .iv(iv),
        .valid(d_valid), .plaintext(d_pt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] f_model(input logic [127:0] x, input logic [127:0] k);
        logic [127:0] t;
        logic [127:0] s;
        t = x ^ k;
        for (int b = 0; b < 16; b++) s[b*8 +: 8] = 8'hFF - t[b*8 +: 8];
        return s ^ ((s << 8) | (s >> 120)) ^ ((s << 32) | (s >> 96));
    endfunction

    function automatic logic [255:0] model_e(input logic [255:0] c);
        logic [127:0] l;
        logic [127:0] r;
        logic [127:0] nl;
        l = c[255:128];
        r = c[127:0];
        for (int i = 0; i < 5; i++) begin
            nl = r;
            r  = l ^ f_model(r, key_tab[i]);
            l  = nl;
        end
        return {l, r};
    endfunction

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic load_tables();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); sbox_valid = 1'b1; sbox_out = 8'(255 - i);
        end
        @(negedge clk); sbox_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); key_tvalid = 1'b1; key = key_tab[i];
        end
        @(negedge clk); key_tvalid = 1'b0;
    endtask

    // Returns the cycle stamp at which the selected valid is first seen, or -1
    task automatic wait_valid(input bit use_dec, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((use_dec ? d_valid : e_valid) === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t0;
        int at;
        int seen;
        logic [255:0] got [5];
        logic [255:0] ct1, ct2, d1, d2;

        key_tab[0] = 128'h000102030405060708090A0B0C0D0E0F;
        key_tab[1] = 128'h101112131415161718191A1B1C1D1E1F;
        key_tab[2] = 128'h202122232425262728292A2B2C2D2E2F;
        key_tab[3] = 128'h303132333435363738393A3B3C3D3E3F;
        key_tab[4] = 128'h404142434445464748494A4B4C4D4E4F;

        // Vector k is the k-th block after reset, so it uses counter iv+k.
        vecs[0].iv = IV;            vecs[0].ct = '0;
        vecs[1].iv = IV;            vecs[1].ct = '0;
        vecs[2].iv = IV - 256'd2;   vecs[2].ct = PT1;
        vecs[3].iv = IV - 256'd3;   vecs[3].ct = PT1 ^ 256'd1;
        vecs[4].iv = '0 - 256'd4;   vecs[4].ct = PT2;
        for (int k = 0; k < 5; k++)
            vecs[k].exp = model_e(vecs[k].iv + 256'(k)) ^ vecs[k].ct;

        reset_n = 1'b0; sbox_valid = 1'b0; sbox_out = '0; key_tvalid = 1'b0; key = '0;
        tb_tvalid = 1'b0; tb_data = '0; iv = IV; chain = 1'b0;
        repeat (3) @(negedge clk);
        check_int("rst_enc_valid", int'(e_valid), 0);
        check256("rst_enc_pt", e_pt, '0);
        check_int("rst_dec_valid", int'(d_valid), 0);
        check256("rst_dec_pt", d_pt, '0);
        reset_n = 1'b1;

        // Table-driven direct decrypt vectors
        load_tables();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); tb_tvalid = 1'b1; tb_data = vecs[k].ct; iv = vecs[k].iv; t0 = cyc;
            @(negedge clk); tb_tvalid = 1'b0;
            wait_valid(1'b1, 40, at);
            check_int($sformatf("vec%0d_latency", k), at - t0, 31);
            check256($sformatf("vec%0d_pt", k), d_pt, vecs[k].exp);
            got[k] = d_pt;
        end
        check256("linearity_bit0", got[2] ^ got[3], 256'd1);

        // Single block through encrypt -> decrypt
        do_reset(); load_tables(); iv = IV; chain = 1'b1;
        @(negedge clk); tb_tvalid = 1'b1; tb_data = PT1; t0 = cyc;
        @(negedge clk); tb_tvalid = 1'b0;
        wait_valid(1'b0, 40, at);
        check_int("enc_latency", at - t0, 31);
        check256("enc_ct", e_pt, PT1 ^ model_e(IV));
        wait_valid(1'b1, 40, at);
        check_int("chain_latency", at - t0, 62);
        check256("roundtrip_pt", d_pt, PT1);

        // Two back-to-back blocks through the chain
        do_reset(); load_tables(); iv = IV; chain = 1'b1;
        @(negedge clk); tb_tvalid = 1'b1; tb_data = PT1; t0 = cyc;
        @(negedge clk); tb_data = PT2;
        @(negedge clk); tb_tvalid = 1'b0;
        wait_valid(1'b0, 40, at);
        check_int("b2b_enc_latency", at - t0, 31);
        ct1 = e_pt;
        @(negedge clk);
        check_int("b2b_enc_valid2", int'(e_valid), 1);
        ct2 = e_pt;
        @(negedge clk);
        check_int("b2b_enc_valid_end", int'(e_valid), 0);
        wait_valid(1'b1, 40, at);
        check_int("b2b_dec_latency", at - t0, 62);
        d1 = d_pt;
        @(negedge clk);
        check_int("b2b_dec_valid2", int'(d_valid), 1);
        d2 = d_pt;
        check256("b2b_pt1", d1, PT1);
        check256("b2b_pt2", d2, PT2);
        checks++;
        if ((ct1 ^ PT1) === (ct2 ^ PT2)) begin
            errors++;
            $display("FAIL b2b_ks_distinct: got equal keystreams %h", ct1 ^ PT1);
        end
        check256("b2b_ks2", ct2 ^ PT2, model_e(IV + 256'd1));

        // Counter wrap: iv = all ones, second block uses counter 0
        do_reset(); load_tables(); iv = '1; chain = 1'b0;
        @(negedge clk); tb_tvalid = 1'b1; tb_data = '0;
        @(negedge clk);
        @(negedge clk); tb_tvalid = 1'b0;
        wait_valid(1'b1, 40, at);
        check256("wrap_ks_first", d_pt, model_e('1));
        @(negedge clk);
        check256("wrap_ks_second", d_pt, model_e('0));

        // Reset ten cycles into a block's flight
        do_reset(); load_tables(); iv = IV; chain = 1'b0;
        @(negedge clk); tb_tvalid = 1'b1; tb_data = PT1;
        @(negedge clk); tb_tvalid = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_valid === 1'b1) seen++;
        end
        check_int("flush_no_valid", seen, 0);
        load_tables();
        @(negedge clk); tb_tvalid = 1'b1; tb_data = '0; t0 = cyc;
        @(negedge clk); tb_tvalid = 1'b0;
        wait_valid(1'b1, 40, at);
        check_int("post_flush_latency", at - t0, 31);
        check256("post_flush_ctr0", d_pt, model_e(IV));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
